scan_decoder: RTL

- Parametrised N-to-2^N one-hot decoder with registered outputs.
- Adds an enable input and a second operating mode.
- Direct mode decodes the select input.
- Scan mode steps autonomously through every output, holding each one for a programmable number of cycles. This suits digit strobing on display and keypad scanners.

---
 rtl/scan_decoder.sv | 83 ++++++++
 1 files changed

// File: rtl/scan_decoder.sv
// N-to-2^N one-hot decoder with registered outputs: direct decode of I, or an autonomous scan holding each output for DWELL cycles.
// Latency: one Clk edge from any input (I, En, Mode, Rst) to D/Idx/Wrap; no combinational input-to-output path.
// No backpressure: the block accepts inputs every cycle; En low blanks D and freezes scan position.
module scan_decoder #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            En,
    input  logic            Mode,
    input  logic [N-1:0]    I,
    output logic [2**N-1:0] D,
    output logic [N-1:0]    Idx,
    output logic            Wrap
);

    localparam int M  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [N-1:0]  idx_nxt;
    logic [N-1:0]  idx_inc;
    logic [M-1:0]  d_nxt;
    logic          wrap_nxt;
    logic [N-1:0]  dec_sel;
    logic          dec_on;

    // Next-state selection: one decoder shared by both modes, fed by whichever index should be shown next.
    always_comb begin
        cnt_nxt  = cnt;
        idx_nxt  = Idx;
        wrap_nxt = 1'b0;
        dec_sel  = Idx;
        dec_on   = 1'b0;
        idx_inc  = Idx + 1'b1;
        d_nxt    = '0;

        if (!Mode) begin
            // Direct mode: any partial dwell is discarded so a later scan starts with a full dwell.
            cnt_nxt = '0;
            if (En) begin
                idx_nxt = I;
                dec_sel = I;
                dec_on  = 1'b1;
            end
        end else if (En) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt  = '0;
                idx_nxt  = idx_inc;
                dec_sel  = idx_inc;
                wrap_nxt = (Idx == IDX_LAST);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            dec_on = 1'b1;
        end
        // Paused scan (Mode=1, En=0) falls through: Idx and cnt hold, D blanks.

        if (dec_on) begin
            d_nxt[dec_sel] = 1'b1;
        end
    end

    // Output and scan-state registers; synchronous reset takes priority over every other input.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            D    <= '0;
            Idx  <= '0;
            Wrap <= 1'b0;
            cnt  <= '0;
        end else begin
            D    <= d_nxt;
            Idx  <= idx_nxt;
            Wrap <= wrap_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule
